dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_responder_tx_fifo.sv | 56 +++++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, MMIO
// register offsets, TX status bit positions and the byte-lane helper.
package dmem_pkg;

    localparam logic [1:0] WC_BYTE = 2'b00;
    localparam logic [1:0] WC_HALF = 2'b01;
    localparam logic [1:0] WC_WORD = 2'b10;
    localparam logic [1:0] WC_RSVD = 2'b11;

    localparam logic [4:0] OFF_MTIME_LO = 5'h00;
    localparam logic [4:0] OFF_MTIME_HI = 5'h04;
    localparam logic [4:0] OFF_MTCMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTCMP_HI = 5'h0C;
    localparam logic [4:0] OFF_TX_DATA  = 5'h10;
    localparam logic [4:0] OFF_TX_STAT  = 5'h14;

    localparam int ST_OVF   = 5;
    localparam int ST_FULL  = 4;
    localparam int ST_EMPTY = 3;

    // Byte lanes touched by an access of size wc at byte offset ofs.
    function automatic logic [3:0] lane_mask(input logic [1:0] wc, input logic [1:0] ofs);
        logic [3:0] m;
        case (wc)
            WC_BYTE: m = 4'b0001 << ofs;
            WC_HALF: m = 4'b0011 << {ofs[1], 1'b0};
            WC_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_responder_tx_fifo.sv
// Console transmit FIFO: power-of-two depth, push accepted when not full
// or when a pop frees a slot in the same cycle; head reads 0 when empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic                     o_push_ok,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == CW'(0));
    assign o_count   = r_count;
    assign w_pop     = i_pop && !o_empty;
    assign o_push_ok = i_push && (!o_full || w_pop);
    assign o_head    = o_empty ? WIDTH'(0) : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_count  <= CW'(0);
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({o_push_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are masked by the empty flag so need no reset.
    always_ff @(posedge clk) begin
        if (o_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: word RAM, 64-bit machine timer with
// interrupt, and a console TX FIFO behind a word-only MMIO window.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          TX_DEPTH  = 4,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [1:0]  wc,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        access_err,
    output logic        timer_irq,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);
    localparam int          IW        = $clog2(RAM_WORDS);
    localparam int          CW        = $clog2(TX_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

    logic [31:0] r_ram [RAM_WORDS];
    logic [63:0] r_mtime;
    logic [63:0] r_mtcmp;
    logic        r_irq;
    logic        r_ovf;

    logic [4:0]    w_off;
    logic          w_in_ram, w_reg_known, w_misalign, w_err;
    logic          w_ram_we, w_mmio_we;
    logic [IW-1:0] w_ram_idx;
    logic [31:0]   w_ram_rd, w_wd_sh, w_mmio_rd, w_status, w_count32;
    logic [3:0]    w_lanes;
    logic [2:0]    w_cnt3;
    logic [63:0]   w_mtime_nx, w_mtcmp_nx;
    logic          w_tx_push, w_tx_pop, w_stat_wr, w_push_ok, w_full, w_empty;
    logic [CW-1:0] w_count;

    // Address decode and access legality.
    assign w_off       = addr[4:0];
    assign w_in_ram    = (addr < RAM_BYTES);
    assign w_reg_known = (addr[31:5] == MMIO_BASE[31:5]) && (w_off <= OFF_TX_STAT);
    assign w_misalign  = ((wc == WC_HALF) && addr[0]) ||
                         ((wc == WC_WORD) && (addr[1:0] != 2'b00));
    assign w_err       = (wc == WC_RSVD) || w_misalign ||
                         !(w_in_ram || w_reg_known) ||
                         (w_reg_known && (wc != WC_WORD));
    assign access_err  = w_err;
    assign w_ram_we    = we && !w_err && w_in_ram;
    assign w_mmio_we   = we && !w_err && w_reg_known;

    // RAM datapath: right-aligned read, lane-shifted write data.
    assign w_ram_idx = addr[IW+1:2];
    assign w_ram_rd  = r_ram[w_ram_idx] >> {addr[1:0], 3'b000};
    assign w_wd_sh   = wd << {addr[1:0], 3'b000};
    assign w_lanes   = lane_mask(wc, addr[1:0]);

    // Byte-lane RAM write; RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i]) r_ram[w_ram_idx][8*i +: 8] <= w_wd_sh[8*i +: 8];
            end
        end
    end

    // Console FIFO.
    assign w_tx_push = w_mmio_we && (w_off == OFF_TX_DATA);
    assign w_stat_wr = w_mmio_we && (w_off == OFF_TX_STAT);
    assign w_tx_pop  = tx_valid && tx_ready;
    assign tx_valid  = !w_empty;

    tx_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_tx_push),
        .i_data    (wd[7:0]),
        .i_pop     (w_tx_pop),
        .o_push_ok (w_push_ok),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count),
        .o_head    (tx_data)
    );

    assign w_count32 = 32'(w_count);
    assign w_cnt3    = (w_count32 > 32'd7) ? 3'd7 : w_count32[2:0];

    // Next timer values: a written half loads wd and suppresses the increment.
    always_comb begin
        w_mtime_nx = r_mtime + 64'd1;
        w_mtcmp_nx = r_mtcmp;
        if (w_mmio_we) begin
            case (w_off)
                OFF_MTIME_LO: w_mtime_nx = {r_mtime[63:32], wd};
                OFF_MTIME_HI: w_mtime_nx = {wd, r_mtime[31:0]};
                OFF_MTCMP_LO: w_mtcmp_nx = {r_mtcmp[63:32], wd};
                OFF_MTCMP_HI: w_mtcmp_nx = {wd, r_mtcmp[31:0]};
                default:      w_mtcmp_nx = r_mtcmp;
            endcase
        end else begin
            w_mtcmp_nx = r_mtcmp;
        end
    end

    // Timer, interrupt and overflow flag state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mtime <= 64'd0;
            r_mtcmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_irq   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nx;
            r_mtcmp <= w_mtcmp_nx;
            r_irq   <= (w_mtime_nx >= w_mtcmp_nx);
            if (w_stat_wr)                    r_ovf <= 1'b0;
            else if (w_tx_push && !w_push_ok) r_ovf <= 1'b1;
            else                              r_ovf <= r_ovf;
        end
    end

    assign timer_irq = r_irq;

    // MMIO read mux.
    always_comb begin
        w_status           = 32'd0;
        w_status[ST_OVF]   = r_ovf;
        w_status[ST_FULL]  = w_full;
        w_status[ST_EMPTY] = w_empty;
        w_status[2:0]      = w_cnt3;
        w_mmio_rd          = 32'd0;
        case (w_off)
            OFF_MTIME_LO: w_mmio_rd = r_mtime[31:0];
            OFF_MTIME_HI: w_mmio_rd = r_mtime[63:32];
            OFF_MTCMP_LO: w_mmio_rd = r_mtcmp[31:0];
            OFF_MTCMP_HI: w_mmio_rd = r_mtcmp[63:32];
            OFF_TX_STAT:  w_mmio_rd = w_status;
            default:      w_mmio_rd = 32'd0;
        endcase
    end

    // Read data select; any faulting access reads zero.
    always_comb begin
        rd = 32'd0;
        if (w_err)         rd = 32'd0;
        else if (w_in_ram) rd = w_ram_rd;
        else               rd = w_mmio_rd;
    end

endmodule
